// File: rtl/tow_referee.sv
// Tug-of-war round referee: turns button edges into arbitrated push events,
// moves the rope, detects wins and false starts, and keeps saturating scores.
module tow_referee #(
    parameter int NUM_POS = 9,
    parameter int POS_W   = 4,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pbl,
    input  logic               pbr,
    input  logic               leds_on,
    input  logic               clear,
    output logic               winrnd,
    output logic               last_win,
    output logic [POS_W-1:0]   rope_pos,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_DARK = 2'd1,
        ST_PLAY = 2'd2,
        ST_WON  = 2'd3
    } st_e;

    localparam logic [POS_W-1:0]   CENTER    = POS_W'((NUM_POS - 1) / 2);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    st_e                st_q, st_d;
    logic [POS_W-1:0]   rope_q, rope_d;
    logic               winrnd_q, winrnd_d;
    logic               last_win_q, last_win_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               pri_q, pri_d;
    logic               pl_q, pr_q;

    logic ev_l_s, ev_r_s, tie_s, gnt_l_s, gnt_r_s, live_s;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == SCORE_MAX) begin
            return v;
        end else begin
            return v + SCORE_ONE;
        end
    endfunction

    // Edge detection and tie arbitration; the pri holder wins a tie.
    always_comb begin
        ev_l_s  = pbl & ~pl_q;
        ev_r_s  = pbr & ~pr_q;
        tie_s   = ev_l_s & ev_r_s;
        gnt_l_s = ev_l_s & (~ev_r_s | ~pri_q);
        gnt_r_s = ev_r_s & (~ev_l_s | pri_q);
        live_s  = ~clear & ((st_q == ST_DARK) | (st_q == ST_PLAY));
    end

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= ST_WAIT;
            rope_q     <= CENTER;
            winrnd_q   <= 1'b0;
            last_win_q <= 1'b0;
            score_l_q  <= {SCORE_W{1'b0}};
            score_r_q  <= {SCORE_W{1'b0}};
            pri_q      <= 1'b0;
            pl_q       <= 1'b0;
            pr_q       <= 1'b0;
        end else begin
            st_q       <= st_d;
            rope_q     <= rope_d;
            winrnd_q   <= winrnd_d;
            last_win_q <= last_win_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            pri_q      <= pri_d;
            pl_q       <= pbl;
            pr_q       <= pbr;
        end
    end

    // Next-state logic; clear overrides every state.
    always_comb begin
        st_d       = st_q;
        rope_d     = rope_q;
        winrnd_d   = winrnd_q;
        last_win_d = last_win_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        pri_d      = pri_q;

        // Priority only rotates on ties that are actually acted upon.
        if (tie_s && live_s) begin
            pri_d = ~pri_q;
        end else begin
            pri_d = pri_q;
        end

        if (clear) begin
            st_d     = ST_WAIT;
            rope_d   = CENTER;
            winrnd_d = 1'b0;
        end else begin
            case (st_q)
                ST_WAIT: begin
                    st_d = leds_on ? ST_PLAY : ST_DARK;
                end
                ST_DARK: begin
                    // A push in the dark hands the round to the opponent.
                    if (gnt_l_s) begin
                        st_d       = ST_WON;
                        score_r_d  = sat_inc(score_r_q);
                        last_win_d = 1'b1;
                        winrnd_d   = 1'b1;
                    end else if (gnt_r_s) begin
                        st_d       = ST_WON;
                        score_l_d  = sat_inc(score_l_q);
                        last_win_d = 1'b0;
                        winrnd_d   = 1'b1;
                    end else if (leds_on) begin
                        st_d = ST_PLAY;
                    end else begin
                        st_d = ST_DARK;
                    end
                end
                ST_PLAY: begin
                    if (gnt_l_s) begin
                        rope_d = rope_q - POS_ONE;
                        if (rope_q == POS_ONE) begin
                            st_d       = ST_WON;
                            score_l_d  = sat_inc(score_l_q);
                            last_win_d = 1'b0;
                            winrnd_d   = 1'b1;
                        end else begin
                            st_d = ST_PLAY;
                        end
                    end else if (gnt_r_s) begin
                        rope_d = rope_q + POS_ONE;
                        if (rope_q == (POS_MAX - POS_ONE)) begin
                            st_d       = ST_WON;
                            score_r_d  = sat_inc(score_r_q);
                            last_win_d = 1'b1;
                            winrnd_d   = 1'b1;
                        end else begin
                            st_d = ST_PLAY;
                        end
                    end else begin
                        st_d = ST_PLAY;
                    end
                end
                ST_WON: begin
                    st_d     = ST_WON;
                    winrnd_d = 1'b1;
                end
                default: begin
                    st_d = ST_WAIT;
                end
            endcase
        end
    end

    assign winrnd   = winrnd_q;
    assign last_win = last_win_q;
    assign rope_pos = rope_q;
    assign score_l  = score_l_q;
    assign score_r  = score_r_q;

endmodule
